// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode constants, control encodings and bundle type for the decode stage
// Contents: OP_* opcodes, ALUOp enum, EXTOp one-hot codes, NPCOp/WDSel/DMType codes,
//           ctrl_t bundle struct, alu_base() funct3 -> base ALU op helper.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [4:0] {
        ALU_NOP    = 5'b00000,
        ALU_LUI, ALU_AUIPC, ALU_ADD, ALU_SUB, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU,
        ALU_BGEU, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL,
        ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU,
        ALU_REM, ALU_REMU
    } alu_op_e;

    localparam logic [5:0] EXT_NONE  = 6'b000000;
    localparam logic [5:0] EXT_J     = 6'b000001;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_SHAMT = 6'b100000;

    localparam logic [2:0] NPC_PC4    = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic       alu_src;
        logic [2:0] dm_type;
        logic [1:0] wd_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrl_t;

    // Arithmetic op selected by funct3 alone (funct7 = 0 variants of R and I types)
    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I(+M) instruction decoder into the control bundle
// Ports: instr (raw word) -> ctrl (control bundle incl. register fields), illegal.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int EN_MEXT = 0
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       bad;
    ctrl_t      c;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    always_comb begin
        c = '0;
        bad = 1'b0;
        case (op)
            OP_R: begin
                c.reg_write = 1'b1;
                if (f7 == 7'b0000000) c.alu_op = alu_base(f3);
                else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) c.alu_op = f3[2] ? ALU_SRA : ALU_SUB;
                else if (f7 == 7'b0000001 && EN_MEXT != 0) c.alu_op = ALU_MUL + {2'b00, f3};
                else bad = 1'b1;
            end
            OP_I: begin
                c.reg_write = 1'b1;
                c.alu_src = 1'b1;
                c.ext_op = (f3 == 3'b001 || f3 == 3'b101) ? EXT_SHAMT : EXT_I;
                c.alu_op = (f3 == 3'b101 && f7 == 7'b0100000) ? ALU_SRA : alu_base(f3);
                bad = (f3 == 3'b001 && f7 != 7'b0000000) ||
                      (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            OP_LOAD: begin
                c.reg_write = 1'b1;
                c.alu_src = 1'b1;
                c.ext_op = EXT_I;
                c.alu_op = ALU_ADD;
                c.wd_sel = WD_MEM;
                case (f3)
                    3'b000:  c.dm_type = DM_B;
                    3'b001:  c.dm_type = DM_H;
                    3'b010:  c.dm_type = DM_W;
                    3'b100:  c.dm_type = DM_BU;
                    3'b101:  c.dm_type = DM_HU;
                    default: bad = 1'b1;
                endcase
            end
            OP_STORE: begin
                c.mem_write = 1'b1;
                c.alu_src = 1'b1;
                c.ext_op = EXT_S;
                c.alu_op = ALU_ADD;
                case (f3)
                    3'b000:  c.dm_type = DM_B;
                    3'b001:  c.dm_type = DM_H;
                    3'b010:  c.dm_type = DM_W;
                    default: bad = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                c.ext_op = EXT_B;
                c.npc_op = NPC_BRANCH;
                case (f3)
                    3'b000:  c.alu_op = ALU_SUB;
                    3'b001:  c.alu_op = ALU_BNE;
                    3'b100:  c.alu_op = ALU_BLT;
                    3'b101:  c.alu_op = ALU_BGE;
                    3'b110:  c.alu_op = ALU_BLTU;
                    3'b111:  c.alu_op = ALU_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                c.reg_write = 1'b1;
                c.ext_op = EXT_J;
                c.npc_op = NPC_JAL;
                c.wd_sel = WD_PC4;
            end
            OP_JALR: begin
                c.reg_write = 1'b1;
                c.alu_src = 1'b1;
                c.ext_op = EXT_I;
                c.alu_op = ALU_ADD;
                c.npc_op = NPC_JALR;
                c.wd_sel = WD_PC4;
                bad = f3 != 3'b000;
            end
            OP_LUI: begin
                c.reg_write = 1'b1;
                c.alu_src = 1'b1;
                c.ext_op = EXT_U;
                c.alu_op = ALU_LUI;
            end
            OP_AUIPC: begin
                c.reg_write = 1'b1;
                c.alu_src = 1'b1;
                c.ext_op = EXT_U;
                c.alu_op = ALU_AUIPC;
            end
            default: bad = 1'b1;
        endcase
        // An illegal instruction carries no side effects: every control field is cleared
        if (bad) c = '0;
        c.rs1 = instr[19:15];
        c.rs2 = instr[24:20];
        c.rd = instr[11:7];
        if (c.rd == 5'd0) c.reg_write = 1'b0;
    end

    assign ctrl = c;
    assign illegal = bad;

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: ID stage control with valid/ready output register, load-use hazard and stall counter
// Ports: clk/rstn; in_valid/in_ready/instr/pc_in from IF/ID; flush; ex_mem_read/ex_rd from EX;
//        out_valid/out_ready plus registered bundle (RegWrite..illegal, pc_out) to EX;
//        stall_clr/stall_cnt load-use stall statistics.
module decode_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int EN_MEXT = 0,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc_in,
    input  logic             flush,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             stall_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [5:0]       EXTOp,
    output logic [4:0]       ALUOp,
    output logic [2:0]       NPCOp,
    output logic             ALUSrc,
    output logic [2:0]       DMType,
    output logic [1:0]       WDSel,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  pc_out,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_t dec_c;
    ctrl_t q_c;
    logic  dec_ill;
    logic  reads_rs1;
    logic  reads_rs2;
    logic  hazard;
    logic  take;

    ctrl_decode #(.EN_MEXT(EN_MEXT)) u_dec (
        .instr   (instr),
        .ctrl    (dec_c),
        .illegal (dec_ill)
    );

    // Source usage follows the opcode format only, so hazard detection does not wait on legality
    assign reads_rs2 = instr[6:0] inside {OP_R, OP_STORE, OP_BRANCH};
    assign reads_rs1 = reads_rs2 || (instr[6:0] inside {OP_I, OP_LOAD, OP_JALR});
    assign hazard = ex_mem_read && ex_rd != 5'd0 &&
                    ((reads_rs1 && instr[19:15] == ex_rd) || (reads_rs2 && instr[24:20] == ex_rd));
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign take = in_valid && in_ready;

    // A free register that cannot take the instruction loads a bubble (out_valid=0, fields held)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            q_c <= '0;
            illegal <= 1'b0;
            pc_out <= '0;
        end else begin
            if (flush) out_valid <= 1'b0;
            else if (!out_valid || out_ready) out_valid <= take;
            if (take) begin
                q_c <= dec_c;
                illegal <= dec_ill;
                pc_out <= pc_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stall_cnt <= '0;
        else if (stall_clr) stall_cnt <= '0;
        else if (in_valid && hazard && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign RegWrite = q_c.reg_write;
    assign MemWrite = q_c.mem_write;
    assign EXTOp = q_c.ext_op;
    assign ALUOp = q_c.alu_op;
    assign NPCOp = q_c.npc_op;
    assign ALUSrc = q_c.alu_src;
    assign DMType = q_c.dm_type;
    assign WDSel = q_c.wd_sel;
    assign rs1 = q_c.rs1;
    assign rs2 = q_c.rs2;
    assign rd = q_c.rd;

endmodule
